// File: rtl/jenkins_pkg.sv
// -----------------------------------------------------------------------------
// jenkins_pkg
// Shared definitions for the streaming lookup3 (hashlittle2) engine:
//   LOOKUP3_GOLDEN - lookup3 seed constant
//   BLOCK_BYTES    - bytes consumed per mix block
//   state_t        - engine FSM encoding
//   round_mode_t   - selects mix or final in jenkins_round
//   rot32          - 32-bit rotate left
//   mask_tail      - keeps the low nbytes bytes of a word, zeroes the rest
// -----------------------------------------------------------------------------
package jenkins_pkg;

    localparam logic [31:0] LOOKUP3_GOLDEN = 32'hdeadbeef;
    localparam int unsigned BLOCK_BYTES    = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MIX   = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        RND_MIX   = 1'b0,
        RND_FINAL = 1'b1
    } round_mode_t;

    function automatic logic [31:0] rot32(input logic [31:0] x, input int unsigned k);
        return (x << k) | (x >> (32 - k));
    endfunction

    // nbytes >= 4 keeps the whole word.
    function automatic logic [31:0] mask_tail(input logic [31:0] word, input logic [2:0] nbytes);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                m[8*i +: 8] = 8'hff;
            end
        end
        return word & m;
    endfunction

endpackage

// File: rtl/jenkins_round.sv
// -----------------------------------------------------------------------------
// jenkins_round
// Purely combinational lookup3 round. mode_i selects between the six-step
// mix() and the seven-step final() of Bob Jenkins' lookup3.
// Ports:
//   mode_i        - RND_MIX or RND_FINAL
//   a_i/b_i/c_i   - internal state in
//   a_o/b_o/c_o   - internal state after the selected round
// -----------------------------------------------------------------------------
module jenkins_round
    import jenkins_pkg::*;
(
    input  round_mode_t mode_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o
);

    logic [31:0] ma, mb, mc;
    logic [31:0] fa, fb, fc;

    // mix(): rotates 4, 6, 8, 16, 19, 4
    always_comb begin
        ma = a_i;
        mb = b_i;
        mc = c_i;
        ma = ma - mc;  ma = ma ^ rot32(mc, 4);   mc = mc + mb;
        mb = mb - ma;  mb = mb ^ rot32(ma, 6);   ma = ma + mc;
        mc = mc - mb;  mc = mc ^ rot32(mb, 8);   mb = mb + ma;
        ma = ma - mc;  ma = ma ^ rot32(mc, 16);  mc = mc + mb;
        mb = mb - ma;  mb = mb ^ rot32(ma, 19);  ma = ma + mc;
        mc = mc - mb;  mc = mc ^ rot32(mb, 4);   mb = mb + ma;
    end

    // final(): rotates 14, 11, 25, 16, 4, 14, 24
    always_comb begin
        fa = a_i;
        fb = b_i;
        fc = c_i;
        fc = fc ^ fb;  fc = fc - rot32(fb, 14);
        fa = fa ^ fc;  fa = fa - rot32(fc, 11);
        fb = fb ^ fa;  fb = fb - rot32(fa, 25);
        fc = fc ^ fb;  fc = fc - rot32(fb, 16);
        fa = fa ^ fc;  fa = fa - rot32(fc, 4);
        fb = fb ^ fa;  fb = fb - rot32(fa, 14);
        fc = fc ^ fb;  fc = fc - rot32(fb, 24);
    end

    always_comb begin
        if (mode_i == RND_FINAL) begin
            a_o = fa;
            b_o = fb;
            c_o = fc;
        end else begin
            a_o = ma;
            b_o = mb;
            c_o = mc;
        end
    end

endmodule

// File: rtl/jenkins_lookup3_stream.sv
// -----------------------------------------------------------------------------
// jenkins_lookup3_stream
// Streaming lookup3 hashlittle2 engine. A request (length, initval) is taken
// in IDLE, the key then arrives as little-endian 32-bit words, and the primary
// (c) and secondary (b) hashes are presented until consumed.
// Ports:
//   CLK, RST_N              - clock, asynchronous active-low reset
//   s_valid/s_ready         - request handshake; s_len bytes, s_initval seed
//   w_valid/w_ready/w_data  - key word stream, byte i at bits 8i+7:8i
//   h_valid/h_ready         - result handshake
//   h_c, h_b                - primary and secondary hash
// -----------------------------------------------------------------------------
module jenkins_lookup3_stream
    import jenkins_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter logic [31:0] GOLDEN = LOOKUP3_GOLDEN
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [LEN_W-1:0] s_len,
    input  logic [31:0]      s_initval,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [31:0]      w_data,
    output logic             h_valid,
    input  logic             h_ready,
    output logic [31:0]      h_c,
    output logic [31:0]      h_b
);

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      c_q, c_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      hc_q, hc_d;
    logic [31:0]      hb_q, hb_d;

    logic             idle_rdy;
    logic             tail_blk;
    logic [LEN_W-1:0] word_off;
    logic [LEN_W-1:0] avail;
    logic [2:0]       word_bytes;
    logic [1:0]       last_idx;
    logic [31:0]      word_in;
    logic [31:0]      seed;
    round_mode_t      rnd_mode;
    logic [31:0]      rnd_a, rnd_b, rnd_c;

    // A block with 12 or fewer bytes remaining is the last one; it skips mix
    // and goes to final, and its words beyond the key length are masked.
    assign tail_blk   = (rem_q <= LEN_W'(BLOCK_BYTES));
    assign word_off   = LEN_W'({idx_q, 2'b00});
    assign avail      = rem_q - word_off;
    assign word_bytes = (avail >= LEN_W'(4)) ? 3'd4 : avail[2:0];
    // Tail block carries ceil(rem/4) words; full blocks always three.
    assign last_idx   = tail_blk ? 2'((rem_q - LEN_W'(1)) >> 2) : 2'd2;
    assign word_in    = tail_blk ? mask_tail(w_data, word_bytes) : w_data;
    assign seed       = GOLDEN + 32'(s_len) + s_initval;

    assign rnd_mode = (state_q == ST_FINAL) ? RND_FINAL : RND_MIX;

    jenkins_round u_round (
        .mode_i (rnd_mode),
        .a_i    (a_q),
        .b_i    (b_q),
        .c_i    (c_q),
        .a_o    (rnd_a),
        .b_o    (rnd_b),
        .c_o    (rnd_c)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        hc_d     = hc_q;
        hb_d     = hb_q;
        idle_rdy = 1'b0;
        w_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_rdy = 1'b1;
                if (s_valid) begin
                    a_d   = seed;
                    b_d   = seed;
                    c_d   = seed;
                    rem_d = s_len;
                    idx_d = 2'd0;
                    if (s_len == '0) begin
                        // Empty key: lookup3 returns the seeded state untouched.
                        hc_d    = seed;
                        hb_d    = seed;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    case (idx_q)
                        2'd0:    a_d = a_q + word_in;
                        2'd1:    b_d = b_q + word_in;
                        2'd2:    c_d = c_q + word_in;
                        default: ;
                    endcase
                    if (idx_q == last_idx) begin
                        idx_d   = 2'd0;
                        state_d = tail_blk ? ST_FINAL : ST_MIX;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            ST_MIX: begin
                a_d     = rnd_a;
                b_d     = rnd_b;
                c_d     = rnd_c;
                rem_d   = rem_q - LEN_W'(BLOCK_BYTES);
                state_d = ST_LOAD;
            end

            ST_FINAL: begin
                a_d     = rnd_a;
                b_d     = rnd_b;
                c_d     = rnd_c;
                hc_d    = rnd_c;
                hb_d    = rnd_b;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (h_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            hc_q    <= '0;
            hb_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            hc_q    <= hc_d;
            hb_q    <= hb_d;
        end
    end

    // State sits in IDLE while reset is held, so gate s_ready with RST_N.
    assign s_ready = idle_rdy & RST_N;
    assign h_valid = (state_q == ST_DONE);
    assign h_c     = hc_q;
    assign h_b     = hb_q;

endmodule

// File: tb/tb_jenkins_lookup3_stream.sv
module tb_jenkins_lookup3_stream;

    localparam int LEN_W = 16;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             s_valid;
    logic             s_ready;
    logic [LEN_W-1:0] s_len;
    logic [31:0]      s_initval;
    logic             w_valid;
    logic             w_ready;
    logic [31:0]      w_data;
    logic             h_valid;
    logic             h_ready;
    logic [31:0]      h_c;
    logic [31:0]      h_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] key_mem [0:511];

    always #5 CLK = ~CLK;

    jenkins_lookup3_stream #(.LEN_W(LEN_W), .GOLDEN(32'hdeadbeef)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_len     (s_len),
        .s_initval (s_initval),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .h_valid   (h_valid),
        .h_ready   (h_ready),
        .h_c       (h_c),
        .h_b       (h_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference hashlittle2 (byte oriented) ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] le_word(input int p);
        return {key_mem[p+3], key_mem[p+2], key_mem[p+1], key_mem[p]};
    endfunction

    task automatic ref_hash(input int len, input logic [31:0] iv,
                            output logic [31:0] rc, output logic [31:0] rb);
        logic [31:0] a, b, c;
        int rest, p;
        a = 32'hdeadbeef + 32'(len) + iv;
        b = a;
        c = a;
        rest = len;
        p = 0;
        while (rest > 12) begin
            a += le_word(p);
            b += le_word(p + 4);
            c += le_word(p + 8);
            a = a - c;  a = a ^ rotl(c, 4);   c = c + b;
            b = b - a;  b = b ^ rotl(a, 6);   a = a + c;
            c = c - b;  c = c ^ rotl(b, 8);   b = b + a;
            a = a - c;  a = a ^ rotl(c, 16);  c = c + b;
            b = b - a;  b = b ^ rotl(a, 19);  a = a + c;
            c = c - b;  c = c ^ rotl(b, 4);   b = b + a;
            rest -= 12;
            p += 12;
        end
        if (rest == 0) begin
            rc = c;
            rb = b;
            return;
        end
        for (int i = 0; i < rest; i++) begin
            case (i / 4)
                0:       a += 32'(key_mem[p+i]) << (8 * (i % 4));
                1:       b += 32'(key_mem[p+i]) << (8 * (i % 4));
                default: c += 32'(key_mem[p+i]) << (8 * (i % 4));
            endcase
        end
        c = c ^ b;  c = c - rotl(b, 14);
        a = a ^ c;  a = a - rotl(c, 11);
        b = b ^ a;  b = b - rotl(a, 25);
        c = c ^ b;  c = c - rotl(b, 16);
        a = a ^ c;  a = a - rotl(c, 4);
        b = b ^ a;  b = b - rotl(a, 14);
        c = c ^ b;  c = c - rotl(b, 24);
        rc = c;
        rb = b;
    endtask

    function automatic int exp_latency(input int len);
        if (len == 0) return 1;
        return 1 + (len + 3) / 4 + ((len + 11) / 12 - 1) + 1;
    endfunction

    // Random key; the bytes after the key inside the last word are garbage.
    task automatic fill_key(input int len);
        for (int i = 0; i < len; i++) key_mem[i] = 8'($urandom);
        for (int i = len; i < len + 4; i++) key_mem[i] = 8'($urandom_range(1, 255));
    endtask

    // Issue one request, stream its words, check the result, optionally
    // stall the result for `hold` cycles, then consume it.
    task automatic run_hash(input string tag, input int len, input logic [31:0] iv,
                            input bit gaps, input int hold,
                            input logic [31:0] exp_c, input logic [31:0] exp_b,
                            output int lat);
        int nw, widx, cyc;
        bit take, surplus;
        nw = (len + 3) / 4;
        widx = 0;
        surplus = 0;
        @(negedge CLK);
        check_val($sformatf("%s_s_ready", tag), 32'(s_ready), 32'd1);
        s_valid   = 1'b1;
        s_len     = LEN_W'(len);
        s_initval = iv;
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        cyc = 1;
        while (!h_valid && cyc < 4000) begin
            @(negedge CLK);
            if (widx < nw && (!gaps || $urandom_range(0, 3) != 0)) begin
                w_valid = 1'b1;
                w_data  = le_word(4 * widx);
            end else begin
                w_valid = 1'b0;
                w_data  = $urandom;
            end
            if (w_ready && widx >= nw) surplus = 1'b1;
            take = w_valid && w_ready;
            @(posedge CLK);
            #1;
            cyc++;
            if (take) widx++;
        end
        w_valid = 1'b0;
        lat = cyc;
        check_val($sformatf("%s_h_valid", tag), 32'(h_valid), 32'd1);
        check_val($sformatf("%s_h_c", tag), h_c, exp_c);
        check_val($sformatf("%s_h_b", tag), h_b, exp_b);
        check_val($sformatf("%s_surplus", tag), 32'(surplus), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            check_val($sformatf("%s_stall_hc%0d", tag, k), h_c, exp_c);
            check_val($sformatf("%s_stall_hb%0d", tag, k), h_b, exp_b);
            check_val($sformatf("%s_stall_vld%0d", tag, k), 32'(h_valid), 32'd1);
            check_val($sformatf("%s_stall_srdy%0d", tag, k), 32'(s_ready), 32'd0);
        end
        @(negedge CLK);
        h_ready = 1'b1;
        @(posedge CLK);
        #1;
        h_ready = 1'b0;
        check_val($sformatf("%s_consumed_vld", tag), 32'(h_valid), 32'd0);
        check_val($sformatf("%s_consumed_srdy", tag), 32'(s_ready), 32'd1);
    endtask

    initial begin
        string       four;
        logic [31:0] ec, eb;
        int          lat;
        int          lens [7];

        lens = '{1, 11, 12, 13, 24, 25, 255};
        for (int i = 0; i < 512; i++) key_mem[i] = 8'h00;

        RST_N     = 1'b0;
        s_valid   = 1'b0;
        s_len     = '0;
        s_initval = '0;
        w_valid   = 1'b0;
        w_data    = '0;
        h_ready   = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_s_ready", 32'(s_ready), 32'd0);
        check_val("rst_w_ready", 32'(w_ready), 32'd0);
        check_val("rst_h_valid", 32'(h_valid), 32'd0);
        check_val("rst_h_c", h_c, 32'd0);
        check_val("rst_h_b", h_b, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Empty keys
        run_hash("len0_iv0", 0, 32'h0, 1'b0, 0, 32'hdeadbeef, 32'hdeadbeef, lat);
        check_val("len0_iv0_lat", 32'(lat), 32'd1);
        run_hash("len0_ivdb", 0, 32'hdeadbeef, 1'b0, 0, 32'hbd5b7dde, 32'hbd5b7dde, lat);

        // Known-answer string, 30 bytes, garbage in the last word's upper bytes
        four = "Four score and seven years ago";
        for (int i = 0; i < 30; i++) key_mem[i] = four[i];
        key_mem[30] = 8'hcd;
        key_mem[31] = 8'hab;
        ref_hash(30, 32'd0, ec, eb);
        run_hash("four_iv0", 30, 32'd0, 1'b0, 0, 32'h17770551, eb, lat);
        check_val("four_iv0_lat", 32'(lat), 32'(exp_latency(30)));
        ref_hash(30, 32'd1, ec, eb);
        run_hash("four_iv1", 30, 32'd1, 1'b0, 0, 32'hcd628161, eb, lat);

        // Block-boundary lengths with random data, full-rate words
        foreach (lens[n]) begin
            logic [31:0] iv;
            iv = $urandom;
            fill_key(lens[n]);
            ref_hash(lens[n], iv, ec, eb);
            run_hash($sformatf("len%0d", lens[n]), lens[n], iv, 1'b0, 0, ec, eb, lat);
            check_val($sformatf("len%0d_lat", lens[n]), 32'(lat), 32'(exp_latency(lens[n])));
        end

        // Word gaps and a 10-cycle result stall
        fill_key(37);
        ref_hash(37, 32'h1234_5678, ec, eb);
        run_hash("gaps37", 37, 32'h1234_5678, 1'b1, 10, ec, eb, lat);

        // Reset in the middle of loading a 100-byte key
        fill_key(100);
        @(negedge CLK);
        s_valid   = 1'b1;
        s_len     = LEN_W'(100);
        s_initval = 32'h0bad_cafe;
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            w_valid = 1'b1;
            w_data  = le_word(4 * k);
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        w_valid = 1'b0;
        check_val("midrst_pre_w_ready", 32'(w_ready), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check_val("midrst_h_valid", 32'(h_valid), 32'd0);
        check_val("midrst_h_c", h_c, 32'd0);
        check_val("midrst_h_b", h_b, 32'd0);
        check_val("midrst_s_ready", 32'(s_ready), 32'd0);
        check_val("midrst_w_ready", 32'(w_ready), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        ref_hash(100, 32'h0bad_cafe, ec, eb);
        run_hash("after_rst", 100, 32'h0bad_cafe, 1'b0, 0, ec, eb, lat);
        check_val("after_rst_lat", 32'(lat), 32'(exp_latency(100)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
